// File: rtl/key_pkg.sv
// Shared definitions for the key debouncer: per-channel FSM state encodings
// and the counter-width helper used to size the confirm and repeat counters.
package key_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED        = 2'b00,
        ST_CONFIRM_PRESS   = 2'b01,
        ST_HELD            = 2'b10,
        ST_CONFIRM_RELEASE = 2'b11
    } key_state_e;

    // Bits needed to count 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_debouncer_if.sv
// Key bus between the raw key source (master) and the debouncer (slave).
interface key_debouncer_if #(
    parameter int N_KEYS = 8
);

    logic [N_KEYS-1:0] key_raw;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;

    modport master (
        output key_raw,
        input  key_level,
        input  key_press,
        input  key_release
    );

    modport slave (
        input  key_raw,
        output key_level,
        output key_press,
        output key_release
    );

endinterface

// File: rtl/key_debounce_ch.sv
// One debounced key channel: 2-flop synchronizer, 4-state confirm FSM and,
// when KEY_DEBOUNCE_REPEAT_EN is defined, an auto-repeat timer while held.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int STABLE_CYCLES = 1000000,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic clk_100mhz,
    input  logic rst,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam int               CNT_W    = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 2 || STABLE_CYCLES > (1 << 24) ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("key_debounce_ch: timing parameter out of range");
    end

    logic [1:0]       sync;
    logic             samp;
    key_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             rpt_fire;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, like the real hardware.
    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], key_raw};
        end
    end

    assign samp = sync[1];

`ifdef KEY_DEBOUNCE_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = cnt_width(RPT_MAX);
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_first;

    // First repeat waits the long delay, later ones the short period.
    assign rpt_fire = (state == ST_HELD) && samp &&
                      (rpt_cnt == (rpt_first ? RPT_DELAY_LAST : RPT_PERIOD_LAST));

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (state != ST_HELD || !samp) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (rpt_fire) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b0;
        end else begin
            rpt_cnt   <= rpt_cnt + RPT_W'(1);
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            state       <= ST_RELEASED;
            cnt         <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            case (state)
                ST_RELEASED: begin
                    if (samp) begin
                        state <= ST_CONFIRM_PRESS;
                        cnt   <= '0;
                    end
                end
                ST_CONFIRM_PRESS: begin
                    if (!samp) begin
                        state <= ST_RELEASED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= ST_HELD;
                        cnt       <= '0;
                        key_level <= 1'b1;
                        key_press <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_HELD: begin
                    if (!samp) begin
                        state <= ST_CONFIRM_RELEASE;
                        cnt   <= '0;
                    end else begin
                        key_press <= rpt_fire;
                    end
                end
                ST_CONFIRM_RELEASE: begin
                    // A bounce back to pressed returns to HELD without a new press pulse.
                    if (samp) begin
                        state <= ST_HELD;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state       <= ST_RELEASED;
                        cnt         <= '0;
                        key_level   <= 1'b0;
                        key_release <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_RELEASED;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_debouncer.sv
// N_KEYS independent debounced key channels on a shared key bus.
// Auto-repeat on held keys is built only when KEY_DEBOUNCE_REPEAT_EN is defined.
module key_debouncer #(
    parameter int N_KEYS        = 8,
    parameter int STABLE_CYCLES = 1000000,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic            clk_100mhz,
    input  logic            rst,
    key_debouncer_if.slave  bus
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_ch (
            .clk_100mhz  (clk_100mhz),
            .rst         (rst),
            .key_raw     (bus.key_raw[i]),
            .key_level   (bus.key_level[i]),
            .key_press   (bus.key_press[i]),
            .key_release (bus.key_release[i])
        );
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with STABLE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3; repeat expectations follow KEY_DEBOUNCE_REPEAT_EN.
module tb_key_debouncer;

    localparam int N_KEYS  = 8;
    localparam int STABLE  = 4;
    localparam int RDELAY  = 10;
    localparam int RPERIOD = 3;

`ifdef KEY_DEBOUNCE_REPEAT_EN
    localparam int N_P3 = 7;
`else
    localparam int N_P3 = 1;
`endif

    logic clk_100mhz = 1'b0;
    logic rst        = 1'b1;

    key_debouncer_if #(.N_KEYS(N_KEYS)) bus ();

    key_debouncer #(
        .N_KEYS        (N_KEYS),
        .STABLE_CYCLES (STABLE),
        .REPEAT_DELAY  (RDELAY),
        .REPEAT_PERIOD (RPERIOD)
    ) dut (
        .clk_100mhz (clk_100mhz),
        .rst        (rst),
        .bus        (bus)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    int n_checks = 0;
    int n_pass   = 0;
    int edge_cnt = 0;
    int both_cnt = 0;
    int press_cnt   [N_KEYS] = '{default: 0};
    int release_cnt [N_KEYS] = '{default: 0};
    bit lvl1_seen = 1'b0;
    int p3_q [$];
    int p3_off [7] = '{0, 10, 13, 16, 19, 22, 25};

    initial forever begin
        @(posedge clk_100mhz);
        edge_cnt++;
    end

    // Output monitor on the falling edge, away from the active edge.
    initial forever begin
        @(negedge clk_100mhz);
        for (int i = 0; i < N_KEYS; i++) begin
            if (bus.key_press[i])   press_cnt[i]++;
            if (bus.key_release[i]) release_cnt[i]++;
        end
        if (|(bus.key_press & bus.key_release)) both_cnt++;
        if (bus.key_level[1]) lvl1_seen = 1'b1;
        if (bus.key_press[3]) p3_q.push_back(edge_cnt);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_100mhz);
        #1;
    endtask

    int d;
    int rel5;

    initial begin
        bus.key_raw = '0;
        tick(3);
        check("rst_level",   32'(bus.key_level),   0);
        check("rst_press",   32'(bus.key_press),   0);
        check("rst_release", 32'(bus.key_release), 0);
        rst = 1'b0;
        tick(2);

        // Single clean press and release on bit 0.
        bus.key_raw = 8'h01;
        tick(6);
        check("t1_level_e6", 32'(bus.key_level), 0);
        check("t1_press_e6", 32'(bus.key_press), 0);
        tick(1);
        check("t1_press_e7", 32'(bus.key_press), 32'h01);
        check("t1_level_e7", 32'(bus.key_level), 32'h01);
        tick(1);
        check("t1_press_e8", 32'(bus.key_press), 0);
        bus.key_raw = 8'h00;
        tick(6);
        check("t1_level_rel_e6",   32'(bus.key_level),   32'h01);
        check("t1_release_rel_e6", 32'(bus.key_release), 0);
        tick(1);
        check("t1_release_rel_e7", 32'(bus.key_release), 32'h01);
        check("t1_level_rel_e7",   32'(bus.key_level),   0);
        tick(3);
        check("t1_press_cnt",   press_cnt[0],   1);
        check("t1_release_cnt", release_cnt[0], 1);

        // Bouncing bit 1 never confirms.
        bus.key_raw = 8'h02; tick(2);
        bus.key_raw = 8'h00; tick(2);
        bus.key_raw = 8'h02; tick(2);
        bus.key_raw = 8'h00; tick(12);
        check("t2_press_cnt",   press_cnt[1],   0);
        check("t2_release_cnt", release_cnt[1], 0);
        check("t2_level_seen",  32'(lvl1_seen), 0);

        // Bit 2 held 20 cycles, then released.
        bus.key_raw = 8'h04;
        tick(6);
        check("t3_press_e6", 32'(bus.key_press), 0);
        tick(1);
        check("t3_press_e7", 32'(bus.key_press), 32'h04);
        check("t3_level_e7", 32'(bus.key_level), 32'h04);
        tick(12);
        check("t3_level_e19", 32'(bus.key_level), 32'h04);
        tick(1);
        bus.key_raw = 8'h00;
        tick(6);
        check("t3_level_rel_e6",   32'(bus.key_level),   32'h04);
        check("t3_release_rel_e6", 32'(bus.key_release), 0);
        tick(1);
        check("t3_release_rel_e7", 32'(bus.key_release), 32'h04);
        check("t3_level_rel_e7",   32'(bus.key_level),   0);
        tick(1);
        check("t3_release_rel_e8", 32'(bus.key_release), 0);
        tick(2);

        // Bit 3 held 30 cycles: press pulses with or without auto-repeat.
        bus.key_raw = 8'h08;
        d = edge_cnt;
        tick(30);
        bus.key_raw = 8'h00;
        tick(12);
        check("t4_pulse_count", p3_q.size(), N_P3);
        check("t4_first_edge", (p3_q.size() > 0) ? p3_q[0] - d : -1, 7);
        for (int i = 1; i < N_P3; i++) begin
            if (i < p3_q.size()) check("t4_repeat_offset", p3_q[i] - p3_q[0], p3_off[i]);
        end
        check("t4_release_cnt", release_cnt[3], 1);

        // Reset while bit 5 is held and bit 4 is mid-confirm.
        bus.key_raw = 8'h20;
        tick(8);
        check("t5_level_pre", 32'(bus.key_level), 32'h20);
        bus.key_raw = 8'h30;
        tick(5);
        rel5 = release_cnt[5];
        rst = 1'b1;
        #1;
        check("t5_rst_level",   32'(bus.key_level),   0);
        check("t5_rst_press",   32'(bus.key_press),   0);
        check("t5_rst_release", 32'(bus.key_release), 0);
        tick(3);
        rst = 1'b0;
        tick(6);
        check("t5_press_e6", 32'(bus.key_press), 0);
        tick(1);
        check("t5_press_e7", 32'(bus.key_press), 32'h30);
        check("t5_level_e7", 32'(bus.key_level), 32'h30);
        tick(1);
        check("t5_no_rst_release", release_cnt[5], rel5);
        bus.key_raw = 8'h00;
        tick(12);

        // All eight keys together.
        bus.key_raw = 8'hFF;
        tick(6);
        check("t6_press_e6", 32'(bus.key_press), 0);
        tick(1);
        check("t6_press_e7", 32'(bus.key_press), 32'hFF);
        check("t6_level_e7", 32'(bus.key_level), 32'hFF);
        tick(1);
        bus.key_raw = 8'h00;
        tick(7);
        check("t6_release_e7", 32'(bus.key_release), 32'hFF);
        check("t6_level_rel",  32'(bus.key_level),   0);
        tick(3);

        check("press_release_overlap", both_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
